// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with request-to-send,
// filtered bus inputs, per-edge watchdog and open-collector pull-low enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_tx_done,
    output logic       o_tx_error,
    output logic       o_busy,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe
);
    localparam int IW = $clog2(INHIBIT_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int FW = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT} state_t;

    // index 0 = clock line, index 1 = data line; idle bus level is high
    logic [1:0]    w_raw, r_meta, r_sync, r_filt;
    logic [FW-1:0] r_fcnt [2];
    logic          w_fall, w_timeout;

    state_t        r_state, w_state;
    logic [7:0]    r_data, w_data;
    logic          r_par, w_par;
    logic [IW-1:0] r_inh, w_inh;
    logic [3:0]    r_bit, w_bit;
    logic [TW-1:0] r_wd, w_wd;
    logic          r_clk_oe, w_clk_oe, r_data_oe, w_data_oe;
    logic          r_done, w_done, r_error, w_error;

    assign w_raw = {i_ps2_data, i_ps2_clk};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_meta <= 2'b11;
            r_sync <= 2'b11;
            r_filt <= 2'b11;
            for (int k = 0; k < 2; k++) r_fcnt[k] <= '0;
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
            for (int k = 0; k < 2; k++) begin
                if (r_sync[k] == r_filt[k]) begin
                    r_fcnt[k] <= '0;
                end else if (r_fcnt[k] == FW'(FILTER_LEN - 1)) begin
                    r_filt[k] <= r_sync[k];
                    r_fcnt[k] <= '0;
                end else begin
                    r_fcnt[k] <= r_fcnt[k] + 1'b1;
                end
            end
        end
    end

    // strobe on the cycle the filtered clock commits to a new low level
    assign w_fall    = r_filt[0] & ~r_sync[0] & (r_fcnt[0] == FW'(FILTER_LEN - 1));
    assign w_timeout = r_wd == TW'(TIMEOUT_CYCLES - 1);

    always_comb begin
        w_state   = r_state;
        w_data    = r_data;
        w_par     = r_par;
        w_inh     = r_inh;
        w_bit     = r_bit;
        w_wd      = r_wd;
        w_clk_oe  = r_clk_oe;
        w_data_oe = r_data_oe;
        w_done    = 1'b0;
        w_error   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_clk_oe  = 1'b0;
                w_data_oe = 1'b0;
                if (i_tx_valid) begin
                    w_data   = i_tx_data;
                    w_par    = ~^i_tx_data;
                    w_clk_oe = 1'b1;
                    w_inh    = '0;
                    w_state  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (r_inh == IW'(INHIBIT_CYCLES - 1)) begin
                    w_data_oe = 1'b1;
                    w_state   = S_REQ;
                end else begin
                    w_inh = r_inh + 1'b1;
                end
            end
            S_REQ: begin
                w_clk_oe = 1'b0;
                w_bit    = '0;
                w_wd     = '0;
                w_state  = S_SHIFT;
            end
            default: begin
                w_wd = r_wd + 1'b1;
                if (w_fall) begin
                    w_wd = '0;
                    if (r_state == S_SHIFT) begin
                        w_bit     = r_bit + 1'b1;
                        w_data_oe = (r_bit == 4'd9) ? 1'b0 : (r_bit == 4'd8) ? ~r_par : ~r_data[r_bit[2:0]];
                        w_state   = (r_bit == 4'd9) ? S_ACK : S_SHIFT;
                    end else if (r_state == S_ACK) begin
                        w_bit     = r_bit + 1'b1;
                        w_data_oe = 1'b0;
                        w_error   = r_filt[1];
                        w_state   = r_filt[1] ? S_IDLE : S_WAIT;
                    end
                end else if (r_state == S_WAIT && r_filt == 2'b11) begin
                    w_done  = 1'b1;
                    w_state = S_IDLE;
                end else if (w_timeout) begin
                    w_clk_oe  = 1'b0;
                    w_data_oe = 1'b0;
                    w_error   = 1'b1;
                    w_state   = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_data    <= '0;
            r_par     <= 1'b0;
            r_inh     <= '0;
            r_bit     <= '0;
            r_wd      <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_data    <= w_data;
            r_par     <= w_par;
            r_inh     <= w_inh;
            r_bit     <= w_bit;
            r_wd      <= w_wd;
            r_clk_oe  <= w_clk_oe;
            r_data_oe <= w_data_oe;
            r_done    <= w_done;
            r_error   <= w_error;
        end
    end

    assign o_tx_ready    = r_state == S_IDLE;
    assign o_busy        = r_state != S_IDLE;
    assign o_tx_done     = r_done;
    assign o_tx_error    = r_error;
    assign o_ps2_clk_oe  = r_clk_oe;
    assign o_ps2_data_oe = r_data_oe;
endmodule
